// File: rtl/cnt_proto_pkg.sv
// rtl/cnt_proto_pkg.sv - shared state encoding and defaults for the count protocol
package cnt_proto_pkg;

  localparam int DEFAULT_TIMEOUT = 50000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TX_WAIT = 3'd1,
    ST_TX_GO   = 3'd2,
    ST_TX_BUSY = 3'd3,
    ST_RX_WAIT = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic logic [8:0] sat_inc9(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - rising-edge detector for a level input
module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;

  // Previous sample resets high so a level already asserted at reset is not seen as new.
  always_ff @(posedge clk) begin
    if (!reset) prev_q <= 1'b1;
    else        prev_q <= in;
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/query_cnt.sv
// rtl/query_cnt.sv - count-protocol initiator: sends N, checks replies 0..N with per-byte timeout
module query_cnt
  import cnt_proto_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       activate,
  input  logic [7:0] count,
  input  logic       tx_active,
  input  logic       tx_done,
  input  logic       rx_ready,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       done,
  output logic       pass,
  output logic [8:0] err_cnt,
  output logic       timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_e        state_q;
  logic [7:0]    n_q;
  logic [8:0]    expected_q;
  logic [8:0]    err_cnt_q;
  logic [TW-1:0] timer_q;
  logic [7:0]    tx_data_q;
  logic          tx_start_q;
  logic          done_q;
  logic          pass_q;
  logic          timeout_q;

  logic          rx_rise;
  logic [8:0]    err_cnt_d;
  logic          last_byte;
  logic          timer_expired;

  edge_detect u_rx_edge (
    .clk   (clk),
    .reset (reset),
    .in    (rx_ready),
    .rise  (rx_rise)
  );

  // Expected is 9 bits wide so N=255 needs 256 replies before the compare matches.
  assign err_cnt_d     = (rx_data != expected_q[7:0]) ? sat_inc9(err_cnt_q) : err_cnt_q;
  assign last_byte     = (expected_q == {1'b0, n_q});
  assign timer_expired = (timer_q == TIMER_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      n_q        <= 8'd0;
      expected_q <= 9'd0;
      err_cnt_q  <= 9'd0;
      timer_q    <= '0;
      tx_data_q  <= 8'd0;
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tx_start_q <= 1'b0;
          done_q     <= 1'b0;
          if (activate && !rx_ready) begin
            n_q        <= count;
            expected_q <= 9'd0;
            err_cnt_q  <= 9'd0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            state_q    <= ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          if (!tx_active) begin
            tx_data_q  <= n_q;
            tx_start_q <= 1'b1;
            state_q    <= ST_TX_GO;
          end
        end
        ST_TX_GO: begin
          tx_start_q <= 1'b0;
          state_q    <= ST_TX_BUSY;
        end
        ST_TX_BUSY: begin
          if (tx_done) begin
            timer_q <= '0;
            state_q <= ST_RX_WAIT;
          end
        end
        ST_RX_WAIT: begin
          if (rx_rise) begin
            err_cnt_q  <= err_cnt_d;
            expected_q <= expected_q + 9'd1;
            timer_q    <= '0;
            if (last_byte) begin
              done_q  <= 1'b1;
              pass_q  <= (err_cnt_d == 9'd0);
              state_q <= ST_DONE;
            end
          end else if (timer_expired) begin
            timer_q   <= timer_q + TW'(1);
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            state_q   <= ST_DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        ST_DONE: begin
          done_q <= 1'b1;
          if (!activate && !rx_ready) begin
            done_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          tx_start_q <= 1'b0;
          done_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err_cnt  = err_cnt_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_query_cnt.sv
// tb/tb_query_cnt.sv - randomized scoreboard bench for query_cnt
module tb_query_cnt;

  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       activate;
  logic [7:0] count;
  logic       tx_active;
  logic       tx_done;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       done;
  logic       pass;
  logic [8:0] err_cnt;
  logic       timeout;

  query_cnt #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .activate  (activate),
    .count     (count),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .rx_ready  (rx_ready),
    .rx_data   (rx_data),
    .tx_data   (tx_data),
    .tx_start  (tx_start),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .timeout   (timeout)
  );

  typedef struct {
    int n;
    int pass;
    int err;
    int tmo;
    int bytes;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int bytes_sent = 0;
  int last_edge = 0;
  int tx_cnt = 0;
  int tx_seen = 0;
  int done_rises = 0;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever done rises, rechecks held results when it falls.
  initial begin
    exp_t cur;
    bit   have = 1'b0;
    bit   dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1) begin
        tx_cnt++;
        tx_seen = int'(tx_data);
      end
      if (done === 1'b1 && !dprev) begin
        done_rises++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected no pending query");
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          chk("pass", int'(pass), cur.pass);
          chk("err_cnt", int'(err_cnt), cur.err);
          chk("timeout", int'(timeout), cur.tmo);
          chk("bytes_before_done", bytes_sent, cur.bytes);
          chk("tx_start_pulses", tx_cnt, 1);
          chk("tx_data_sent", tx_seen, cur.n);
          chk("tx_data_hold", int'(tx_data), cur.n);
          if (cur.tmo != 0) chk("timeout_latency", cyc - last_edge, TMO);
          tx_cnt = 0;
        end
      end
      if (done === 1'b0 && dprev && have && reset === 1'b1) begin
        chk("pass_hold", int'(pass), cur.pass);
        chk("err_cnt_hold", int'(err_cnt), cur.err);
        chk("timeout_hold", int'(timeout), cur.tmo);
      end
      dprev = (done === 1'b1);
    end
  end

  task automatic send_byte(input int v);
    rx_data  = 8'(v);
    rx_ready = 1'b1;
    bytes_sent++;
    last_edge = cyc + 1;
    repeat ($urandom_range(1, 2)) tick();
    rx_ready = 1'b0;
    repeat ($urandom_range(1, 3)) tick();
  endtask

  // Starts a query and plays the UART transmitter; returns 0 if tx_start never came.
  task automatic start_and_tx(input int n, input bit stray, input bit drop_act, output bit ok);
    ok        = 1'b0;
    tx_active = 1'($urandom_range(0, 1));
    count     = 8'(n);
    activate  = 1'b1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (i == 3) tx_active = 1'b0;
      if (tx_start) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("tx_start_seen", 0, 1);
      return;
    end
    count = 8'($urandom);
    if (drop_act) activate = 1'b0;
    tx_active = 1'b1;
    repeat ($urandom_range(1, 3)) tick();
    if (stray) begin
      rx_data  = 8'hA5;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
    end
    tx_active = 1'b0;
    tx_done   = 1'b1;
    last_edge = cyc + 1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic run_query(input int n, input int replies[$], input bit stray, input bit drop_act);
    exp_t e;
    int   err = 0;
    int   start;
    bit   ok;
    foreach (replies[i]) if (replies[i] != i) err++;
    e.n     = n;
    e.bytes = replies.size();
    e.tmo   = (replies.size() < n + 1) ? 1 : 0;
    e.err   = err;
    e.pass  = (e.tmo == 0 && err == 0) ? 1 : 0;
    exp_q.push_back(e);
    bytes_sent = 0;
    start = done_rises;
    start_and_tx(n, stray, drop_act, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      activate = 1'b0;
      return;
    end
    foreach (replies[i]) send_byte(replies[i]);
    for (int i = 0; i < TMO + 50 && done_rises == start; i++) tick();
    chk("done_reached", done_rises - start, 1);
    activate = 1'b0;
    rx_ready = 1'b0;
    for (int i = 0; i < 10 && done; i++) tick();
    chk("done_release", int'(done), 0);
    tick();
  endtask

  task automatic reset_mid_query();
    bit ok;
    bytes_sent = 0;
    start_and_tx(6, 1'b0, 1'b0, ok);
    if (!ok) return;
    send_byte(0);
    send_byte(1);
    reset = 1'b0;
    tick();
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_tx_start", int'(tx_start), 0);
    chk("rst_mid_err_cnt", int'(err_cnt), 0);
    chk("rst_mid_timeout", int'(timeout), 0);
    reset  = 1'b1;
    tx_cnt = 0;
  endtask

  initial begin
    int r[$];
    int n;
    int nsend;
    reset     = 1'b0;
    activate  = 1'b0;
    count     = 8'd0;
    tx_active = 1'b0;
    tx_done   = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'd0;
    repeat (3) tick();
    chk("rst_done", int'(done), 0);
    chk("rst_tx_start", int'(tx_start), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    chk("rst_tx_data", int'(tx_data), 0);
    reset = 1'b1;
    tick();

    r = '{0, 1, 2, 3};
    run_query(3, r, 1'b0, 1'b0);
    r = '{0};
    run_query(0, r, 1'b0, 1'b0);
    r.delete();
    for (int i = 0; i < 256; i++) r.push_back(i);
    run_query(255, r, 1'b0, 1'b0);
    r = '{0, 1, 7, 3, 4};
    run_query(4, r, 1'b0, 1'b0);
    r = '{0, 1};
    run_query(5, r, 1'b0, 1'b0);

    reset_mid_query();
    r = '{0, 1, 2};
    run_query(2, r, 1'b0, 1'b0);

    for (int t = 0; t < 10; t++) begin
      n = $urandom_range(0, 12);
      nsend = ($urandom_range(0, 4) == 0) ? $urandom_range(0, n) : n + 1;
      r.delete();
      for (int i = 0; i < nsend; i++)
        r.push_back(($urandom_range(0, 3) == 0) ? (i + $urandom_range(1, 255)) % 256 : i);
      run_query(n, r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
